uart: RTL and testbench
=======================

Name: uart

Overview:
- Board-level UART transmitter for the demo board.
- A rising edge on push-button btn1 sends a fixed 7-byte ASCII message "HELLO\r\n" on txd.
- sw4/sw5 select the baud rate; sw8 enables even parity.
- rts is driven low for the duration of the message, as an active-low request-to-send.

Parameters:
- BASE_DIV, 5208: clocks per bit at the slowest rate (9600 Bd at 50 MHz); minimum 16. Benches use 16.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn1  input  1  send button, asynchronous to clk; a rising edge starts a message.
- sw4  input  1  baud select bit 0.
- sw5  input  1  baud select bit 1.
- sw8  input  1  parity enable; 1 = even parity bit inserted.
- rts  output  1  active-low request-to-send; 0 while a message is in progress.
- txd  output  1  serial data, idle high.

Behaviour:
- Reset (async, rst=1): txd=1, rts=1, state IDLE, char index 0, bit/baud counters 0, button sync flops 0. Effective immediately and mid-frame; the message is abandoned and is not resumed after reset releases.
- btn1 passes through 2 synchronizer flops plus a third history flop. start = sync2 & ~sync3.
- If btn1 is first sampled high at edge N, then at edge N+2:
  - txd drives the start bit;
  - rts goes 0.
- btn1 held high sends exactly one message; a new message needs release and a new press.
- Edges of btn1 while a message is in progress are ignored (not queued).
- Bit period P = BASE_DIV >> {sw5,sw4}: 00→BASE_DIV, 01→/2, 10→/4, 11→/8 (9600/19200/38400/76800 Bd at default).
- sw4, sw5 and sw8 are latched at the start of each character. Changes mid-character take effect on the next character.
- Frame per character:
  - start bit 0;
  - 8 data bits, LSB first;
  - if sw8=1, an even-parity bit (XOR of the data bits);
  - 1 stop bit = 1.
  - Every bit lasts exactly P clocks.
- FSM: IDLE → START → DATA(8) → PARITY (skipped when parity is disabled) → STOP.
  - After STOP: go to the next START if the char index < 6, else go to IDLE.
- Characters are back-to-back. The next start bit begins on the clock immediately after the previous stop bit's P clocks.
- Message ROM, index 0..6: 0x48, 0x45, 0x4C, 0x4C, 0x4F, 0x0D, 0x0A.
- rts stays 0 from the first start bit through the end of the last stop bit. It returns to 1 in the same cycle the FSM re-enters IDLE.
- Message length: 7×10×P clocks without parity, 7×11×P clocks with parity.
- Baud counter: counts 0..P-1 within each bit; wraps to 0 at bit advance. Width is sufficient for BASE_DIV.
- txd and rts are registered outputs (glitch-free).

Test Plan:
- Reset: rst=1 with btn1=1 → txd=1, rts=1 for the whole reset. Release rst with btn1 held (BASE_DIV=16, switches 00) → start bit 2 clocks after btn1 is sampled high.
- Message content, no parity, sw=000: press btn1.
  - Required: 7 frames of 160 clocks each, 1120 clocks total.
  - First frame bits: 0,0,0,0,1,0,0,1,0,1 (0x48).
  - Decoded bytes in order: 48 45 4C 4C 4F 0D 0A.
  - rts=0 for exactly 1120 clocks, then 1; txd=1 afterwards.
- Parity, sw8=1:
  - 0x48 frame carries parity bit 0; 0x45 frame carries parity bit 1.
  - Each frame lasts 176 clocks.
- Baud select: {sw5,sw4}=11 with BASE_DIV=16 → 2 clocks per bit, frame of 20 clocks. {sw5,sw4}=01 → 8 clocks per bit.
- Held/retrigger:
  - btn1 held high after the message completes → no second message.
  - btn1 pulsed again mid-message → ignored.
  - Release then press again → exactly one new message.
- Reset mid-frame: assert rst during data bit 3 of char 2 → txd=1 and rts=1 immediately. After release, no output until a new btn1 rising edge.

Source files
------------

// File: rtl/uart.sv
// Push-button UART transmitter: a btn1 rising edge sends "HELLO\r\n" on txd,
// with per-character baud select and optional even parity.
module uart #(
   parameter int BASE_DIV = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic btn1,
   input  logic sw4,
   input  logic sw5,
   input  logic sw8,
   output logic rts,
   output logic txd
);

   localparam int CW = $clog2(BASE_DIV + 1);
   localparam logic [CW-1:0] DIV = CW'(BASE_DIV);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          r_state, w_state_next;
   logic            r_sync1, r_sync2, r_sync3;
   logic [CW-1:0]   r_baud, w_baud_next;
   logic [2:0]      r_bit, w_bit_next;
   logic [2:0]      r_char, w_char_next;
   logic [7:0]      r_data, w_data_next;
   logic            r_par_bit, w_par_bit_next;
   logic            r_par_en, w_par_en_next;
   logic [1:0]      r_sel, w_sel_next;
   logic            r_txd, w_txd_next;
   logic            r_rts, w_rts_next;

   logic            w_start;
   logic [CW-1:0]   w_period;
   logic            w_bit_done;
   logic            w_load;
   logic [2:0]      w_load_idx;
   logic [7:0]      w_load_byte;

   function automatic logic [7:0] msg_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    msg_byte = 8'h48;
         3'd1:    msg_byte = 8'h45;
         3'd2:    msg_byte = 8'h4C;
         3'd3:    msg_byte = 8'h4C;
         3'd4:    msg_byte = 8'h4F;
         3'd5:    msg_byte = 8'h0D;
         default: msg_byte = 8'h0A;
      endcase
   endfunction

   assign w_start    = r_sync2 & ~r_sync3;
   assign w_period   = DIV >> r_sel;
   assign w_bit_done = (r_baud == w_period - CW'(1));

   always_comb begin
      w_state_next   = r_state;
      w_baud_next    = '0;
      w_bit_next     = r_bit;
      w_char_next    = r_char;
      w_data_next    = r_data;
      w_par_bit_next = r_par_bit;
      w_par_en_next  = r_par_en;
      w_sel_next     = r_sel;
      w_txd_next     = r_txd;
      w_rts_next     = r_rts;
      w_load         = 1'b0;
      w_load_idx     = 3'd0;
      w_load_byte    = 8'h00;

      if (r_state != S_IDLE && !w_bit_done)
         w_baud_next = r_baud + CW'(1);

      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_load     = 1'b1;
               w_load_idx = 3'd0;
            end
         end
         S_START: begin
            if (w_bit_done) begin
               w_state_next = S_DATA;
               w_bit_next   = 3'd0;
               w_txd_next   = r_data[0];
            end
         end
         S_DATA: begin
            if (w_bit_done) begin
               if (r_bit == 3'd7) begin
                  w_state_next = r_par_en ? S_PARITY : S_STOP;
                  w_txd_next   = r_par_en ? r_par_bit : 1'b1;
               end else begin
                  // Shift so the next data bit always sits at r_data[0].
                  w_bit_next  = r_bit + 3'd1;
                  w_data_next = {1'b0, r_data[7:1]};
                  w_txd_next  = r_data[1];
               end
            end
         end
         S_PARITY: begin
            if (w_bit_done) begin
               w_state_next = S_STOP;
               w_txd_next   = 1'b1;
            end
         end
         S_STOP: begin
            if (w_bit_done) begin
               if (r_char == 3'd6) begin
                  w_state_next = S_IDLE;
                  w_char_next  = 3'd0;
                  w_txd_next   = 1'b1;
                  w_rts_next   = 1'b1;
               end else begin
                  w_load     = 1'b1;
                  w_load_idx = r_char + 3'd1;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_txd_next   = 1'b1;
            w_rts_next   = 1'b1;
         end
      endcase

      // Switches are sampled only here, so each character keeps its own settings.
      if (w_load) begin
         w_load_byte    = msg_byte(w_load_idx);
         w_state_next   = S_START;
         w_char_next    = w_load_idx;
         w_data_next    = w_load_byte;
         w_par_bit_next = ^w_load_byte;
         w_par_en_next  = sw8;
         w_sel_next     = {sw5, sw4};
         w_baud_next    = '0;
         w_txd_next     = 1'b0;
         w_rts_next     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync3   <= 1'b0;
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit     <= 3'd0;
         r_char    <= 3'd0;
         r_data    <= 8'h00;
         r_par_bit <= 1'b0;
         r_par_en  <= 1'b0;
         r_sel     <= 2'b00;
         r_txd     <= 1'b1;
         r_rts     <= 1'b1;
      end else begin
         r_sync1   <= btn1;
         r_sync2   <= r_sync1;
         r_sync3   <= r_sync2;
         r_state   <= w_state_next;
         r_baud    <= w_baud_next;
         r_bit     <= w_bit_next;
         r_char    <= w_char_next;
         r_data    <= w_data_next;
         r_par_bit <= w_par_bit_next;
         r_par_en  <= w_par_en_next;
         r_sel     <= w_sel_next;
         r_txd     <= w_txd_next;
         r_rts     <= w_rts_next;
      end
   end

   assign txd = r_txd;
   assign rts = r_rts;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: captures txd while rts is low and compares it
// against a frame-level reference model and a mid-bit sampling decoder.
module tb_uart;

   localparam int BD = 16;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic btn1 = 1'b1;
   logic sw4  = 1'b0;
   logic sw5  = 1'b0;
   logic sw8  = 1'b0;
   logic rts;
   logic txd;

   int n_pass  = 0;
   int n_total = 0;

   logic cap_q[$];
   logic exp_q[$];
   logic [7:0] msg [7] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

   uart #(.BASE_DIV(BD)) dut (
      .clk  (clk),
      .rst  (rst),
      .btn1 (btn1),
      .sw4  (sw4),
      .sw5  (sw5),
      .sw8  (sw8),
      .rts  (rts),
      .txd  (txd)
   );

   always #5 clk = ~clk;

   // Reference waveform: frame 0 uses (p0,par0), frames 1..6 use (p1,par1).
   function automatic void build_exp(input int p0, input bit par0, input int p1, input bit par1);
      exp_q.delete();
      for (int f = 0; f < 7; f++) begin
         int p;
         bit pe;
         logic [7:0] b;
         p  = (f == 0) ? p0 : p1;
         pe = (f == 0) ? par0 : par1;
         b  = msg[f];
         for (int k = 0; k < p; k++) exp_q.push_back(1'b0);
         for (int i = 0; i < 8; i++)
            for (int k = 0; k < p; k++) exp_q.push_back(b[i]);
         if (pe)
            for (int k = 0; k < p; k++) exp_q.push_back(^b);
         for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
      end
   endfunction

   // Records txd on every falling edge while rts is low; optional mid-message
   // switch change and btn1 glitch, indexed by captured-sample count.
   task automatic capture(input int change_at, input logic [2:0] new_sw,
                          input int pulse_at, output int lat);
      cap_q.delete();
      lat = 0;
      while (rts !== 1'b0 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (rts !== 1'b0) return;
      while (rts === 1'b0 && cap_q.size() < 3000) begin
         cap_q.push_back(txd);
         if (cap_q.size() == change_at) {sw8, sw5, sw4} = new_sw;
         if (cap_q.size() == pulse_at) btn1 = 1'b0;
         if (cap_q.size() == pulse_at + 4) btn1 = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic check_message(input string name, input int lat,
                                input int p0, input bit par0, input int p1, input bit par1);
      int exp_len, off;
      n_total++;
      if (lat !== 3) $display("FAIL %s latency: got %0d cycles, want 3", name, lat);
      else n_pass++;

      build_exp(p0, par0, p1, par1);
      exp_len = p0 * (par0 ? 11 : 10) + 6 * p1 * (par1 ? 11 : 10);
      n_total++;
      if (cap_q.size() !== exp_len)
         $display("FAIL %s rts_low_len: got %0d, want %0d", name, cap_q.size(), exp_len);
      else n_pass++;

      off = 0;
      for (int f = 0; f < 7; f++) begin
         int p, flen, bad;
         logic [7:0] got;
         p    = (f == 0) ? p0 : p1;
         flen = p * (((f == 0) ? par0 : par1) ? 11 : 10);
         bad  = 0;
         for (int k = 0; k < flen; k++)
            if (off + k >= cap_q.size() || cap_q[off + k] !== exp_q[off + k]) bad++;
         n_total++;
         if (bad != 0) $display("FAIL %s frame%0d waveform: %0d bad cycles, want 0", name, f, bad);
         else n_pass++;

         got = 8'hxx;
         for (int i = 0; i < 8; i++) begin
            int s;
            s = off + (1 + i) * p + p / 2;
            if (s < cap_q.size()) got[i] = cap_q[s];
         end
         n_total++;
         if (got !== msg[f]) $display("FAIL %s byte%0d: got %h, want %h", name, f, got, msg[f]);
         else n_pass++;
         off += flen;
      end

      n_total++;
      if (txd !== 1'b1 || rts !== 1'b1)
         $display("FAIL %s idle_after: txd=%b rts=%b, want 1 1", name, txd, rts);
      else n_pass++;
   endtask

   task automatic count_busy(input int n, output int bad);
      bad = 0;
      repeat (n) begin
         @(negedge clk);
         if (txd !== 1'b1 || rts !== 1'b1) bad++;
      end
   endtask

   task automatic release_btn();
      btn1 = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic send(input string name, input logic [2:0] sw);
      int lat;
      int p;
      {sw8, sw5, sw4} = sw;
      p = BD >> sw[1:0];
      @(negedge clk);
      btn1 = 1'b1;
      capture(-1, 3'b000, -1, lat);
      check_message(name, lat, p, sw[2], p, sw[2]);
      $display("msg %s sw8=%b sel=%b P=%0d len=%0d", name, sw[2], sw[1:0], p, cap_q.size());
      release_btn();
   endtask

   task automatic test_reset();
      int bad, lat;
      {sw8, sw5, sw4} = 3'b000;
      btn1 = 1'b1;
      count_busy(20, bad);
      n_total++;
      if (bad != 0) $display("FAIL reset_hold: %0d cycles with txd/rts low, want 0", bad);
      else n_pass++;
      rst = 1'b0;
      capture(-1, 3'b000, -1, lat);
      check_message("reset_release", lat, BD, 1'b0, BD, 1'b0);
      $display("reset release latency=%0d len=%0d", lat, cap_q.size());
      release_btn();
   endtask

   task automatic test_message_noparity();
      send("noparity", 3'b000);
      n_total++;
      if (cap_q.size() !== 1120) $display("FAIL noparity_1120: got %0d, want 1120", cap_q.size());
      else n_pass++;
   endtask

   task automatic test_parity();
      send("parity", 3'b100);
      n_total++;
      if (cap_q.size() < 329 || cap_q[152] !== 1'b0 || cap_q[328] !== 1'b1)
         $display("FAIL parity_bits: frame0/1 parity wrong (len %0d), want 0 then 1", cap_q.size());
      else n_pass++;
   endtask

   task automatic test_baud();
      send("baud11", 3'b011);
      send("baud01", 3'b001);
      send("baud10", 3'b010);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         logic [2:0] sw;
         sw = 3'($urandom_range(0, 7));
         send($sformatf("rand%0d", r), sw);
      end
   endtask

   task automatic test_switch_change();
      int lat, p0, p1;
      logic [2:0] sw0, sw1;
      sw0 = 3'($urandom_range(0, 7));
      sw1 = ~sw0;
      p0 = BD >> sw0[1:0];
      p1 = BD >> sw1[1:0];
      {sw8, sw5, sw4} = sw0;
      @(negedge clk);
      btn1 = 1'b1;
      capture(5, sw1, -1, lat);
      check_message("swchange", lat, p0, sw0[2], p1, sw1[2]);
      $display("msg swchange %b->%b len=%0d", sw0, sw1, cap_q.size());
      release_btn();
   endtask

   task automatic test_back_to_back();
      int lat, bad;
      {sw8, sw5, sw4} = 3'b000;
      @(negedge clk);
      btn1 = 1'b1;
      capture(-1, 3'b000, 100, lat);
      check_message("retrig_first", lat, BD, 1'b0, BD, 1'b0);
      count_busy(300, bad);
      n_total++;
      if (bad != 0) $display("FAIL held_no_resend: %0d busy cycles, want 0", bad);
      else n_pass++;
      $display("msg retrig_first len=%0d held_busy=%0d", cap_q.size(), bad);
      release_btn();
      btn1 = 1'b1;
      capture(-1, 3'b000, -1, lat);
      check_message("retrig_second", lat, BD, 1'b0, BD, 1'b0);
      release_btn();
      count_busy(200, bad);
      n_total++;
      if (bad != 0) $display("FAIL single_resend: %0d busy cycles, want 0", bad);
      else n_pass++;
      $display("msg retrig_second len=%0d after_busy=%0d", cap_q.size(), bad);
   endtask

   task automatic test_reset_midframe();
      int w, bad, lat;
      {sw8, sw5, sw4} = 3'b000;
      @(negedge clk);
      btn1 = 1'b1;
      w = 0;
      while (rts !== 1'b0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      repeat (2 * 10 * BD + 4 * BD + BD / 2) @(negedge clk);
      n_total++;
      if (rts !== 1'b0) $display("FAIL midframe_busy: rts=%b, want 0", rts);
      else n_pass++;
      btn1 = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_total++;
      if (txd !== 1'b1 || rts !== 1'b1)
         $display("FAIL midframe_async: txd=%b rts=%b, want 1 1", txd, rts);
      else n_pass++;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      count_busy(200, bad);
      n_total++;
      if (bad != 0) $display("FAIL midframe_no_resume: %0d busy cycles, want 0", bad);
      else n_pass++;
      $display("reset midframe: post-release busy=%0d", bad);
      btn1 = 1'b1;
      capture(-1, 3'b000, -1, lat);
      check_message("after_midreset", lat, BD, 1'b0, BD, 1'b0);
      release_btn();
   endtask

   initial begin
      test_reset();
      test_message_noparity();
      test_parity();
      test_baud();
      test_random();
      test_switch_change();
      test_back_to_back();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
